// File: rtl/tl45_wb_sram_responder_if.sv
// Pipelined Wishbone B4 bus bundle between a TL45 master and the SRAM responder.
interface tl45_wb_sram_responder_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        ack;
    logic        stall;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  ack, stall, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output ack, stall, err, rdata
    );
endinterface

// File: rtl/tl45_wb_sram_responder.sv
// Pipelined Wishbone B4 responder over a word-addressed RAM with fixed ack latency
// and bounded outstanding requests. Define TL45_WB_RESP_ADDR_ERR_EN to error out-of-range addresses.
module tl45_wb_sram_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2,
    parameter int MAX_OUT   = 4
) (
    input logic                        i_clk,
    input logic                        i_reset,
    tl45_wb_sram_responder_if.slave    wb
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MAX_OUT + 1);

    // Stage 0 captures at the accept edge; the response leaves stage LATENCY,
    // so it is visible in the cycle after edge k+LATENCY.
    logic [LATENCY:0]        valid_q, valid_d;
    logic [LATENCY:0]        err_q,   err_d;
    logic [LATENCY:0][31:0]  data_q,  data_d;
    logic [CW-1:0]           count_q, count_d;

    logic [31:0] mem [MEM_WORDS];
    logic [IW-1:0] idx;
    logic addr_err, resp, stall, accept, mem_we, ack;
    logic [31:0] rd_word;

    assign idx = wb.addr[IW-1:0];

`ifdef TL45_WB_RESP_ADDR_ERR_EN
    assign addr_err = (wb.addr >> IW) != 30'd0;
`else
    logic unused_addr_hi;
    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^(wb.addr >> IW);
`endif

    // NOTE: every variable assigned here gets a value on every path (defaults first), so no latches.
    always_comb begin
        resp    = valid_q[LATENCY] && wb.cyc;
        stall   = (count_q == CW'(MAX_OUT)) && !resp;
        accept  = wb.cyc && wb.stb && !stall;
        mem_we  = accept && wb.we && !addr_err && !i_reset;
        rd_word = (wb.we || addr_err) ? 32'd0 : mem[idx];

        valid_d = {valid_q[LATENCY-1:0], accept};
        err_d   = {err_q[LATENCY-1:0], accept && addr_err};
        data_d  = {data_q[LATENCY-1:0], rd_word};

        count_d = count_q;
        case ({accept, resp})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Cycle abort drops everything in flight; committed writes stay committed.
        if (!wb.cyc) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            err_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Data is qualified by valid_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        data_q <= data_d;
    end

    // NOTE: the RAM array is deliberately not reset; contents survive i_reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.sel[b]) mem[idx][8*b +: 8] <= wb.wdata[8*b +: 8];
            end
        end
    end

    assign ack      = resp && !err_q[LATENCY];
    assign wb.ack   = ack;
    assign wb.stall = stall;
    assign wb.rdata = ack ? data_q[LATENCY] : 32'd0;
`ifdef TL45_WB_RESP_ADDR_ERR_EN
    assign wb.err   = resp && err_q[LATENCY];
`else
    assign wb.err   = 1'b0;
`endif
endmodule

// File: tb/tb_tl45_wb_sram_responder.sv
// Scoreboard bench: drivers push expected responses, negedge monitors pop and compare.
module tb_tl45_wb_sram_responder;
    localparam int LAT = 2;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc_n = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_a[$];
    exp_t q_s[$];

    tl45_wb_sram_responder_if wa ();
    tl45_wb_sram_responder_if ws ();

    tl45_wb_sram_responder #(.MEM_WORDS(1024), .LATENCY(LAT), .MAX_OUT(4)) u_a (
        .i_clk(clk), .i_reset(rst), .wb(wa)
    );
    tl45_wb_sram_responder #(.MEM_WORDS(1024), .LATENCY(LAT), .MAX_OUT(1)) u_s (
        .i_clk(clk), .i_reset(rst), .wb(ws)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors sample 2 time units after the falling edge, after any driver update.
    always @(negedge clk) begin : mon_a
        exp_t e;
        #2;
        if (wa.ack || wa.err) begin
            if (q_a.size() == 0) check("a_unexpected_resp", {wa.ack, wa.err}, 2'b00);
            else begin
                e = q_a.pop_front();
                check("a_resp_kind", {wa.ack, wa.err}, e.err ? 2'b01 : 2'b10);
                check("a_resp_data", wa.rdata, e.data);
                check("a_resp_cycle", cyc_n, e.due);
            end
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        #2;
        if (ws.ack || ws.err) begin
            if (q_s.size() == 0) check("s_unexpected_resp", {ws.ack, ws.err}, 2'b00);
            else begin
                e = q_s.pop_front();
                check("s_resp_kind", {ws.ack, ws.err}, e.err ? 2'b01 : 2'b10);
                check("s_resp_data", ws.rdata, e.data);
                check("s_resp_cycle", cyc_n, e.due);
            end
        end
    end

    // Issue one request on DUT a (which=0) or s (which=1); returns stall cycles waited and accept edge.
    task automatic req(input bit which, input logic we, input logic [29:0] addr,
                       input logic [31:0] data, input logic [3:0] sel,
                       input logic exp_err, input logic [31:0] exp_data,
                       output int waited, output int acc_edge);
        logic st;
        waited = 0;
        acc_edge = -1;
        @(negedge clk);
        if (which) begin
            ws.stb = 1; ws.we = we; ws.addr = addr; ws.wdata = data; ws.sel = sel;
        end else begin
            wa.stb = 1; wa.we = we; wa.addr = addr; wa.wdata = data; wa.sel = sel;
        end
        #1;
        st = which ? ws.stall : wa.stall;
        while (st) begin
            waited++;
            if (waited > 50) begin
                check("req_stall_timeout", 1'b1, 1'b0);
                return;
            end
            @(negedge clk); #1;
            st = which ? ws.stall : wa.stall;
        end
        acc_edge = cyc_n + 1;
        if (which) q_s.push_back('{exp_err, exp_data, acc_edge + LAT});
        else       q_a.push_back('{exp_err, exp_data, acc_edge + LAT});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        wa.stb = 0; ws.stb = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, e, prev;
        wa.cyc = 1; wa.stb = 0; wa.we = 0; wa.addr = '0; wa.wdata = '0; wa.sel = '0;
        ws.cyc = 1; ws.stb = 0; ws.we = 0; ws.addr = '0; ws.wdata = '0; ws.sel = '0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_a_ack",   wa.ack,   1'b0);
        check("rst_a_err",   wa.err,   1'b0);
        check("rst_a_data",  wa.rdata, 32'd0);
        check("rst_a_stall", wa.stall, 1'b0);
        check("rst_s_stall", ws.stall, 1'b0);
        check("rst_a_count", u_a.count_q, 0);
        rst = 0;

        // Basic write then immediate read-after-write.
        req(0, 1, 30'h10, 32'hDEADBEEF, 4'hF, 0, 32'd0, w, e);
        req(0, 0, 30'h10, 32'd0, 4'h0, 0, 32'hDEADBEEF, w, e);
        idle(3);

        // Byte enables and a sel=0 no-op write.
        req(0, 1, 30'h20, 32'h11223344, 4'hF, 0, 32'd0, w, e);
        req(0, 1, 30'h20, 32'hAABBCCDD, 4'b0101, 0, 32'd0, w, e);
        req(0, 0, 30'h20, 32'd0, 4'h0, 0, 32'h11BB33DD, w, e);
        req(0, 1, 30'h20, 32'hFFFFFFFF, 4'h0, 0, 32'd0, w, e);
        req(0, 0, 30'h20, 32'd0, 4'h0, 0, 32'h11BB33DD, w, e);
        idle(3);

        // Back-to-back burst with defaults: no stall at any request.
        for (int i = 0; i < 4; i++) req(0, 1, 30'(i), 32'hA0000000 + 32'(i), 4'hF, 0, 32'd0, w, e);
        for (int i = 0; i < 4; i++) begin
            req(0, 0, 30'(i), 32'd0, 4'h0, 0, 32'hA0000000 + 32'(i), w, e);
            check("burst_no_stall", w, 0);
        end
        idle(4);

        // MAX_OUT=1: every accept after the first waits 2 stalled cycles, spacing LATENCY+1.
        for (int i = 0; i < 4; i++) req(1, 1, 30'(i), 32'hB0000000 + 32'(i), 4'hF, 0, 32'd0, w, e);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            req(1, 0, 30'(i), 32'd0, 4'h0, 0, 32'hB0000000 + 32'(i), w, e);
            if (i > 0) begin
                check("limit_stall_cycles", w, 2);
                check("limit_accept_spacing", e - prev, 3);
            end
            prev = e;
        end
        idle(4);

        // Out-of-range address.
`ifdef TL45_WB_RESP_ADDR_ERR_EN
        req(0, 0, 30'h400, 32'd0, 4'h0, 1, 32'd0, w, e);
        req(0, 1, 30'h400, 32'h55555555, 4'hF, 1, 32'd0, w, e);
        req(0, 0, 30'h000, 32'd0, 4'h0, 0, 32'hA0000000, w, e);
`else
        req(0, 0, 30'h400, 32'd0, 4'h0, 0, 32'hA0000000, w, e);
`endif
        idle(4);

        // Abort: two reads in flight, drop cyc for one cycle.
        req(0, 0, 30'h1, 32'd0, 4'h0, 0, 32'hA0000001, w, e);
        req(0, 0, 30'h2, 32'd0, 4'h0, 0, 32'hA0000002, w, e);
        @(negedge clk);
        wa.stb = 0; wa.cyc = 0;
        q_a.delete();
        @(negedge clk);
        wa.cyc = 1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_count", u_a.count_q, 0);
        check("abort_stall", wa.stall, 1'b0);

        // Reset: known word at 0x40, then write 0x30 + read in flight, reset with a
        // simultaneous write to 0x40 that must be discarded.
        req(0, 1, 30'h40, 32'h12345678, 4'hF, 0, 32'd0, w, e);
        idle(3);
        req(0, 1, 30'h30, 32'hCAFEF00D, 4'hF, 0, 32'd0, w, e);
        req(0, 0, 30'h2, 32'd0, 4'h0, 0, 32'hA0000002, w, e);
        @(negedge clk);
        wa.we = 1; wa.addr = 30'h40; wa.wdata = 32'hFFFFFFFF; wa.sel = 4'hF;
        rst = 1;
        q_a.delete();
        @(negedge clk);
        wa.stb = 0; rst = 0;
        repeat (4) @(negedge clk);
        #1;
        check("reset_count", u_a.count_q, 0);
        check("reset_stall", wa.stall, 1'b0);
        req(0, 0, 30'h30, 32'd0, 4'h0, 0, 32'hCAFEF00D, w, e);
        req(0, 0, 30'h40, 32'd0, 4'h0, 0, 32'h12345678, w, e);
        idle(6);

        check("a_queue_drained", q_a.size(), 0);
        check("s_queue_drained", q_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
